// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable glitch-free 50%-duty clock divider, period 2*(D+1) CLK_IN cycles
module clk_div_prog #(
  parameter int DIV_W = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = '0
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             GATE_EN,
  input  logic [DIV_W-1:0] DIV_IN,
  input  logic             DIV_LOAD,
  output logic             DIV_BUSY,
  output logic [DIV_W-1:0] DIV_ACTIVE,
  output logic             CLK_OUT,
  output logic             CLK_EN_OUT
);
  typedef enum logic [1:0] {IDLE, HI, LO} state_t;
  state_t           r_state, w_state;
  logic [DIV_W-1:0] r_cnt, w_cnt, r_pend, r_active;
  logic             r_busy, r_clk, r_en, w_clk, w_rise, w_end;
  assign w_end = r_cnt == r_active;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_clk = r_clk;
    w_rise = 1'b0;
    case (r_state)
      IDLE: begin
        w_rise = GATE_EN;
        w_state = GATE_EN ? HI : IDLE;
        w_clk = GATE_EN;
        w_cnt = '0;
      end
      HI: begin
        w_state = w_end ? LO : HI;
        w_clk = !w_end;
        w_cnt = w_end ? '0 : r_cnt + 1'b1;
      end
      LO: begin
        w_rise = w_end && GATE_EN;
        w_state = !w_end ? LO : GATE_EN ? HI : IDLE;
        w_clk = w_end && GATE_EN;
        w_cnt = w_end ? '0 : r_cnt + 1'b1;
      end
      default: begin
        w_state = IDLE;
        w_clk = 1'b0;
        w_cnt = '0;
      end
    endcase
  end
  // a pending divisor is swapped in on the rising edge so each period uses one D throughout
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_clk <= 1'b0;
      r_en <= 1'b0;
      r_pend <= DEFAULT_DIV;
      r_active <= DEFAULT_DIV;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_clk <= w_clk;
      r_en <= w_rise;
      r_pend <= DIV_LOAD ? DIV_IN : r_pend;
      r_active <= (w_rise && r_busy) ? r_pend : r_active;
      r_busy <= DIV_LOAD || (r_busy && !w_rise);
    end
  end
  assign DIV_BUSY = r_busy;
  assign DIV_ACTIVE = r_active;
  assign CLK_OUT = r_clk;
  assign CLK_EN_OUT = r_en;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scoreboard of expected CLK_OUT pulses (high/low lengths, divisor, busy) for clk_div_prog
module tb_clk_div_prog;
  logic       CLK_IN = 1'b0;
  logic       RST_N = 1'b0;
  logic       GATE_EN = 1'b0;
  logic [7:0] DIV_IN = '0;
  logic       DIV_LOAD = 1'b0;
  logic       DIV_BUSY, CLK_OUT, CLK_EN_OUT;
  logic [7:0] DIV_ACTIVE;
  clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(8'd0)) dut (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .GATE_EN(GATE_EN), .DIV_IN(DIV_IN), .DIV_LOAD(DIV_LOAD),
    .DIV_BUSY(DIV_BUSY), .DIV_ACTIVE(DIV_ACTIVE), .CLK_OUT(CLK_OUT), .CLK_EN_OUT(CLK_EN_OUT)
  );
  always #5 CLK_IN = ~CLK_IN;
  typedef struct {int hi; int lo; int d; logic b;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  int hcnt = 0, lcnt = 0;
  logic prev = 1'b0, en_bad = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic push(input int hi, input int lo, input int d, input logic b);
    q.push_back('{hi, lo, d, b});
  endtask
  task automatic step();
    exp_t e;
    @(negedge CLK_IN);
    if (!prev && CLK_OUT) begin
      chk("pulse_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        if (q[0].lo >= 0) chk("lo_len", lcnt, q[0].lo);
        chk("en_first", CLK_EN_OUT, 1);
        chk("busy_at_rise", DIV_BUSY, q[0].b);
        chk("d_at_rise", DIV_ACTIVE, q[0].d);
      end
      hcnt = 1;
    end else if (prev && CLK_OUT) begin
      hcnt++;
      if (CLK_EN_OUT) en_bad = 1'b1;
    end else if (prev && !CLK_OUT) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("hi_len", hcnt, e.hi);
      end
      chk("en_single", en_bad, 0);
      en_bad = 1'b0;
      lcnt = 1;
    end else begin
      lcnt++;
      if (CLK_EN_OUT) en_bad = 1'b1;
    end
    prev = CLK_OUT;
  endtask
  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) step();
    chk("drain", q.size(), 0);
  endtask
  task automatic wait_rise(input int budget);
    for (int i = 0; i < budget && !CLK_OUT; i++) step();
    chk("rise_seen", CLK_OUT, 1);
  endtask
  initial begin
    repeat (3) step();
    chk("rst_clk", CLK_OUT, 0);
    chk("rst_en", CLK_EN_OUT, 0);
    chk("rst_busy", DIV_BUSY, 0);
    chk("rst_active", DIV_ACTIVE, 0);
    RST_N = 1'b1;
    repeat (3) step();
    chk("idle_low", CLK_OUT, 0);
    push(1, -1, 0, 0);
    repeat (3) push(1, 1, 0, 0);
    GATE_EN = 1'b1;
    step();
    chk("rise_lat", CLK_OUT, 1);
    drain(50);
    push(1, 1, 0, 1);
    push(4, 1, 3, 0);
    push(4, 4, 3, 0);
    DIV_IN = 8'd3;
    DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0;
    drain(50);
    push(3, 4, 2, 0);
    DIV_IN = 8'd2;
    DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0;
    wait_rise(20);
    step();
    GATE_EN = 1'b0;
    drain(20);
    repeat (10) step();
    chk("idle_park", CLK_OUT, 0);
    chk("idle_active", DIV_ACTIVE, 2);
    push(3, -1, 2, 0);
    GATE_EN = 1'b1;
    step();
    chk("regate_lat", CLK_OUT, 1);
    drain(20);
    push(6, 3, 5, 1);
    push(2, 6, 1, 0);
    push(2, 2, 1, 0);
    DIV_IN = 8'd5;
    DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0;
    step();
    DIV_IN = 8'd1;
    DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0;
    drain(60);
    push(2, 2, 1, 0);
    DIV_IN = 8'd1;
    DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0;
    chk("same_busy", DIV_BUSY, 1);
    drain(20);
    push(256, 2, 255, 0);
    push(256, 256, 255, 0);
    DIV_IN = 8'd255;
    DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0;
    drain(2000);
    push(5, 256, 255, 0);
    wait_rise(300);
    repeat (4) step();
    #2 RST_N = 1'b0;
    #1;
    chk("arst_clk", CLK_OUT, 0);
    chk("arst_en", CLK_EN_OUT, 0);
    chk("arst_active", DIV_ACTIVE, 0);
    chk("arst_busy", DIV_BUSY, 0);
    step();
    chk("arst_drain", q.size(), 0);
    step();
    push(1, -1, 0, 0);
    push(1, 1, 0, 0);
    RST_N = 1'b1;
    step();
    chk("rst_rel_lat", CLK_OUT, 1);
    drain(20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable, glitch-free, 50%-duty clock divider.
- Sits directly upstream of the clock-generator hierarchy. It derives the divided clock from the system clock and drives the generator's CLK_IN.
- CLK_OUT is a flop output, so STA can treat it as a clean generated clock (divide_by = 2*(D+1)).
- Ratio changes and gating take effect only at period boundaries, so no runt pulses occur.

Parameters:
- DIV_W, 8, width of the divisor field D.
- DEFAULT_DIV, 0, reset value of the active divisor D (0 gives divide-by-2).

Ports:
- CLK_IN  input  1  system clock; all flops clock on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- GATE_EN  input  1  1 = run the divided clock; 0 = park CLK_OUT low at the next period end.
- DIV_IN  input  DIV_W  requested divisor D; output period = 2*(D+1) CLK_IN cycles.
- DIV_LOAD  input  1  one-cycle strobe that captures DIV_IN into the pending register.
- DIV_BUSY  output  1  1 while a captured divisor is pending and not yet applied.
- DIV_ACTIVE  output  DIV_W  divisor currently in use.
- CLK_OUT  output  1  divided clock, registered.
- CLK_EN_OUT  output  1  one-cycle pulse, asserted in the first CLK_IN cycle of each CLK_OUT high phase.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE, CLK_OUT=0, CLK_EN_OUT=0, cnt=0.
  - DIV_ACTIVE=DEFAULT_DIV, pending=DEFAULT_DIV, DIV_BUSY=0.
- Reset deassertion is synchronized by the parent. Reset asserted mid-period forces CLK_OUT=0 immediately; a truncated high pulse is acceptable only on reset.
- State machine (cnt is DIV_W bits and never exceeds DIV_ACTIVE):
  - IDLE: CLK_OUT=0. If GATE_EN=1: apply pending if DIV_BUSY, then CLK_OUT<=1, CLK_EN_OUT<=1, cnt<=0, go to HI. Otherwise stay in IDLE.
  - HI: if cnt==DIV_ACTIVE: CLK_OUT<=0, cnt<=0, go to LO. Otherwise cnt<=cnt+1.
  - LO: if cnt!=DIV_ACTIVE: cnt<=cnt+1.
  - LO with cnt==DIV_ACTIVE and GATE_EN=1: apply pending if DIV_BUSY, then CLK_OUT<=1, CLK_EN_OUT<=1, cnt<=0, go to HI.
  - LO with cnt==DIV_ACTIVE and GATE_EN=0: go to IDLE; CLK_OUT stays 0.
- CLK_EN_OUT is 0 in every other cycle.
- Resulting waveform: high phase and low phase are each D+1 cycles. D=0 toggles every cycle; D=2^DIV_W-1 gives period 2^(DIV_W+1).
- Applying pending: DIV_ACTIVE<=pending and DIV_BUSY<=0, on the same edge that CLK_OUT rises. The new period uses the new D from its first cycle.
- DIV_LOAD handling:
  - DIV_LOAD=1: pending<=DIV_IN and DIV_BUSY<=1 on the next edge.
  - A repeated load while busy overwrites pending; last load wins.
  - DIV_LOAD on the same edge as an apply: the old pending is applied, DIV_IN becomes the new pending, and DIV_BUSY stays 1.
  - A load that writes the same value as DIV_ACTIVE still sets DIV_BUSY until it is applied.
- GATE_EN is sampled only in IDLE and at the LO end-of-period edge. Toggling GATE_EN mid-period has no effect on the current period.
- Latency:
  - Leaving IDLE: CLK_OUT rises 1 cycle after GATE_EN is seen high.
  - A load issued during a period is applied at the next rising edge of CLK_OUT.

Test Plan:
- Reset with DEFAULT_DIV=0 -> all outputs 0 and DIV_ACTIVE=0. GATE_EN=1 -> CLK_OUT rises 1 cycle later, then toggles every cycle (period 2). CLK_EN_OUT pulses every 2 cycles.
- Load D=3 while running at D=0 -> DIV_BUSY=1 until the next CLK_OUT rise. The following periods are 8 cycles with 4 high and 4 low. DIV_ACTIVE=3 and DIV_BUSY=0 from that edge.
- At D=2, drop GATE_EN midway through a high phase -> the full 3-high/3-low period completes, then CLK_OUT holds 0 in IDLE. Raise GATE_EN -> CLK_OUT rises on the next edge with a full 3-cycle high phase.
- Loads of D=5 then D=1 while busy; D=1 lands on the apply edge -> D=5 is applied (period 12), D=1 stays pending with DIV_BUSY=1, then D=1 is applied (period 4).
- D=255 (DIV_W=8) -> period 512 cycles, cnt never wraps past 255, 50% duty exact.
- Assert RST_N=0 mid high phase -> CLK_OUT and CLK_EN_OUT go 0 asynchronously and DIV_ACTIVE=DEFAULT_DIV. After release with GATE_EN=1, the first high phase is a full D+1 cycles.
